// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU issue/capture sequencer.
// FuncOp codes, flag bit indices and the sequencer FSM state encoding.
package alu_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXEC_LO = 2'd1,
      EXEC_HI = 2'd2,
      HOLD    = 2'd3
   } seq_state_e;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_AND  = 4'h2,
      OP_OR   = 4'h3,
      OP_XOR  = 4'h4,
      OP_PASS = 4'h5
   } func_op_e;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   // IFlags for the first pass: carry-in only when the request asks for it.
   function automatic logic [3:0] issue_iflags(input logic [3:0] flags, input logic use_carry);
      issue_iflags         = flags;
      issue_iflags[FLAG_C] = flags[FLAG_C] & use_carry;
   endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer FSM and handshake control; the current state is exported on `state`.
// EXEC_HI is only reachable when ALU_SEQ_WIDE_EN is defined.
module alu_seq_ctrl
   import alu_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   input  logic       req_wide,
   input  logic       rsp_ready,
   output logic       req_ready,
   output logic       rsp_valid,
   output logic       accept,
   output logic       lo_pass,
   output logic       hi_pass,
   output logic       finish,
   output seq_state_e state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // ready depends only on state, and valid/payload are held until that transfer.
   seq_state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      lo_pass   = 1'b0;
      hi_pass   = 1'b0;
      finish    = 1'b0;
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == HOLD);
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               accept  = 1'b1;
               state_d = EXEC_LO;
            end
         end
         EXEC_LO: begin
            lo_pass = 1'b1;
`ifdef ALU_SEQ_WIDE_EN
            if (req_wide) begin
               state_d = EXEC_HI;
            end else begin
               state_d = HOLD;
               finish  = 1'b1;
            end
`else
            state_d = HOLD;
            finish  = 1'b1;
`endif
         end
         EXEC_HI: begin
`ifdef ALU_SEQ_WIDE_EN
            hi_pass = 1'b1;
            state_d = HOLD;
            finish  = 1'b1;
`else
            state_d = IDLE;
`endif
         end
         HOLD: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign state = state_q;

`ifndef ALU_SEQ_WIDE_EN
   logic unused_wide;
   assign unused_wide = req_wide;
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Registered issue/capture front end for the combinational ALU, owning the flag register.
// Define ALU_SEQ_WIDE_EN to enable two-pass carry-chained double-width operations.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int DataWidth = 16,
   parameter int FlagBits  = 4
) (
   input  logic                     Clock,
   input  logic                     Reset_n,
   input  logic                     ReqValid,
   output logic                     ReqReady,
   input  logic [3:0]               ReqOp,
   input  logic [2*DataWidth-1:0]   ReqA,
   input  logic [2*DataWidth-1:0]   ReqB,
   input  logic                     ReqUseCarry,
   input  logic                     ReqWide,
   output logic [DataWidth-1:0]     AluA,
   output logic [DataWidth-1:0]     AluB,
   output logic [3:0]               AluFuncOp,
   output logic [FlagBits-1:0]      AluIFlags,
   input  logic [DataWidth-1:0]     AluY,
   input  logic [FlagBits-1:0]      AluOFlags,
   output logic                     RspValid,
   input  logic                     RspReady,
   output logic [2*DataWidth-1:0]   RspY,
   output logic [FlagBits-1:0]      RspFlags,
   output logic [FlagBits-1:0]      Flags
);

   logic       accept, lo_pass, hi_pass, finish, op_wide;
   seq_state_e seq_state;

   logic [DataWidth-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]             alu_op_q, alu_op_d;
   logic [FlagBits-1:0]    alu_if_q, alu_if_d;
   logic [2*DataWidth-1:0] rsp_y_q, rsp_y_d;
   logic [FlagBits-1:0]    rsp_flags_q, rsp_flags_d;
   logic [FlagBits-1:0]    flags_q, flags_d;
`ifdef ALU_SEQ_WIDE_EN
   logic [DataWidth-1:0]   a_hi_q, a_hi_d, b_hi_q, b_hi_d;
   logic [FlagBits-1:0]    lo_flags_q, lo_flags_d;
   logic                   wide_q, wide_d;
   assign op_wide = wide_q;
`else
   assign op_wide = 1'b0;
`endif

   alu_seq_ctrl u_ctrl (
      .clk       (Clock),
      .rst_n     (Reset_n),
      .req_valid (ReqValid),
      .req_wide  (op_wide),
      .rsp_ready (RspReady),
      .req_ready (ReqReady),
      .rsp_valid (RspValid),
      .accept    (accept),
      .lo_pass   (lo_pass),
      .hi_pass   (hi_pass),
      .finish    (finish),
      .state     (seq_state)
   );

   always_comb begin
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      alu_if_d    = alu_if_q;
      rsp_y_d     = rsp_y_q;
      rsp_flags_d = rsp_flags_q;
      flags_d     = flags_q;
`ifdef ALU_SEQ_WIDE_EN
      a_hi_d      = a_hi_q;
      b_hi_d      = b_hi_q;
      lo_flags_d  = lo_flags_q;
      wide_d      = wide_q;
`endif
      if (accept) begin
         alu_a_d  = ReqA[DataWidth-1:0];
         alu_b_d  = ReqB[DataWidth-1:0];
         alu_op_d = ReqOp;
         alu_if_d = issue_iflags(flags_q, ReqUseCarry);
`ifdef ALU_SEQ_WIDE_EN
         a_hi_d   = ReqA[2*DataWidth-1:DataWidth];
         b_hi_d   = ReqB[2*DataWidth-1:DataWidth];
         wide_d   = ReqWide;
`endif
      end
      if (lo_pass) begin
         rsp_y_d = {{DataWidth{1'b0}}, AluY};
         if (!op_wide) begin
            rsp_flags_d = AluOFlags;
         end
`ifdef ALU_SEQ_WIDE_EN
         lo_flags_d = AluOFlags;
         if (wide_q) begin
            // High pass chains the low pass's carry straight into IFlags.
            alu_a_d  = a_hi_q;
            alu_b_d  = b_hi_q;
            alu_if_d = AluOFlags;
         end
`endif
      end
`ifdef ALU_SEQ_WIDE_EN
      if (hi_pass) begin
         rsp_y_d[2*DataWidth-1:DataWidth] = AluY;
         rsp_flags_d         = AluOFlags;
         rsp_flags_d[FLAG_Z] = AluOFlags[FLAG_Z] & lo_flags_q[FLAG_Z];
      end
`endif
      if (finish) begin
         flags_d = rsp_flags_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         alu_if_q    <= '0;
         rsp_y_q     <= '0;
         rsp_flags_q <= '0;
         flags_q     <= '0;
`ifdef ALU_SEQ_WIDE_EN
         a_hi_q      <= '0;
         b_hi_q      <= '0;
         lo_flags_q  <= '0;
         wide_q      <= 1'b0;
`endif
      end else begin
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         alu_if_q    <= alu_if_d;
         rsp_y_q     <= rsp_y_d;
         rsp_flags_q <= rsp_flags_d;
         flags_q     <= flags_d;
`ifdef ALU_SEQ_WIDE_EN
         a_hi_q      <= a_hi_d;
         b_hi_q      <= b_hi_d;
         lo_flags_q  <= lo_flags_d;
         wide_q      <= wide_d;
`endif
      end
   end

   assign AluA      = alu_a_q;
   assign AluB      = alu_b_q;
   assign AluFuncOp = alu_op_q;
   assign AluIFlags = alu_if_q;
   assign RspY      = rsp_y_q;
   assign RspFlags  = rsp_flags_q;
   assign Flags     = flags_q;

   logic unused_ok;
`ifdef ALU_SEQ_WIDE_EN
   assign unused_ok = ^{seq_state};
`else
   assign unused_ok = ^{seq_state, hi_pass, ReqWide,
                        ReqA[2*DataWidth-1:DataWidth], ReqB[2*DataWidth-1:DataWidth]};
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural ALU closes the loop, a vector table
// plus hand-written reset, backpressure and issue-interval sequences check the results.
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic        ReqValid = 1'b0;
   logic        ReqReady;
   logic [3:0]  ReqOp = 4'h0;
   logic [31:0] ReqA = '0, ReqB = '0;
   logic        ReqUseCarry = 1'b0, ReqWide = 1'b0;
   logic [15:0] AluA, AluB, AluY;
   logic [3:0]  AluFuncOp, AluIFlags, AluOFlags;
   logic        RspValid;
   logic        RspReady = 1'b0;
   logic [31:0] RspY;
   logic [3:0]  RspFlags, Flags;

   int n_cmp = 0;
   int n_bad = 0;

   alu_sequencer dut (
      .Clock(Clock), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB), .ReqUseCarry(ReqUseCarry), .ReqWide(ReqWide),
      .AluA(AluA), .AluB(AluB), .AluFuncOp(AluFuncOp), .AluIFlags(AluIFlags),
      .AluY(AluY), .AluOFlags(AluOFlags), .RspValid(RspValid), .RspReady(RspReady),
      .RspY(RspY), .RspFlags(RspFlags), .Flags(Flags)
   );

   always #5 Clock = ~Clock;

   // Behavioural ALU: ADD/SUB consume IFlags.C as carry/borrow in.
   logic [16:0] alu_s;
   always_comb begin
      alu_s     = '0;
      AluY      = '0;
      AluOFlags = '0;
      case (AluFuncOp)
         OP_ADD:  alu_s = {1'b0, AluA} + {1'b0, AluB} + {16'b0, AluIFlags[FLAG_C]};
         OP_SUB:  alu_s = {1'b0, AluA} - {1'b0, AluB} - {16'b0, AluIFlags[FLAG_C]};
         OP_AND:  alu_s = {1'b0, AluA & AluB};
         default: alu_s = {1'b0, AluA};
      endcase
      AluY              = alu_s[15:0];
      AluOFlags[FLAG_C] = alu_s[16];
      AluOFlags[FLAG_Z] = (alu_s[15:0] == 16'h0);
      AluOFlags[FLAG_N] = alu_s[15];
      if (AluFuncOp == OP_ADD)
         AluOFlags[FLAG_V] = (AluA[15] == AluB[15]) && (alu_s[15] != AluA[15]);
      else if (AluFuncOp == OP_SUB)
         AluOFlags[FLAG_V] = (AluA[15] != AluB[15]) && (alu_s[15] != AluA[15]);
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        uc;
      logic        wide;
      logic        exp_ic;
      logic [31:0] exp_y;
      logic [3:0]  exp_f;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic uc, input logic wide, input logic exp_ic,
                               input logic [31:0] exp_y, input logic [3:0] exp_f, input int exp_lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.uc = uc; v.wide = wide; v.exp_ic = exp_ic;
      v.exp_y = exp_y; v.exp_f = exp_f; v.exp_lat = exp_lat;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Presents one request, checks issue-side registers, waits for the response (not released).
   task automatic issue(input vec_t v, input string tag);
      int lat;
      ReqValid = 1'b1; ReqOp = v.op; ReqA = v.a; ReqB = v.b;
      ReqUseCarry = v.uc; ReqWide = v.wide;
      check({tag, " req_ready"}, {31'b0, ReqReady}, 32'd1);
      tick();
      ReqValid = 1'b0;
      check({tag, " alu_a"}, {16'b0, AluA}, {16'b0, v.a[15:0]});
      check({tag, " alu_iflags_c"}, {31'b0, AluIFlags[FLAG_C]}, {31'b0, v.exp_ic});
      lat = 0;
      while (!RspValid && lat < 6) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, v.exp_lat);
      check({tag, " rsp_y"}, RspY, v.exp_y);
      check({tag, " rsp_flags"}, {28'b0, RspFlags}, {28'b0, v.exp_f});
      check({tag, " flags_reg"}, {28'b0, Flags}, {28'b0, v.exp_f});
   endtask

   task automatic release_rsp(input string tag);
      RspReady = 1'b1;
      tick();
      RspReady = 1'b0;
      check({tag, " rsp_valid_drop"}, {31'b0, RspValid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int accepts;
      logic bad;
      vec_t bp;

      vecs[0] = mk(OP_ADD, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b0, 32'h0000_8000, 4'hC, 1);
      vecs[1] = mk(OP_SUB, 32'h0005, 32'h0005, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h2, 1);
      vecs[2] = mk(OP_ADD, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h3, 1);
      vecs[3] = mk(OP_ADD, 32'h0001, 32'h0001, 1'b1, 1'b0, 1'b1, 32'h0000_0003, 4'h0, 1);
      vecs[4] = mk(OP_ADD, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h3, 1);
      vecs[5] = mk(OP_ADD, 32'h0001, 32'h0001, 1'b0, 1'b0, 1'b0, 32'h0000_0002, 4'h0, 1);
      vecs[6] = mk(OP_AND, 32'hF0F0, 32'h0FF0, 1'b0, 1'b0, 1'b0, 32'h0000_00F0, 4'h0, 1);
`ifdef ALU_SEQ_WIDE_EN
      vecs[7] = mk(OP_ADD, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h0001_0000, 4'h0, 2);
`else
      vecs[7] = mk(OP_ADD, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'h3, 1);
`endif
      vecs[8] = mk(OP_SUB, 32'h0003, 32'h0005, 1'b0, 1'b0, 1'b0, 32'h0000_FFFE, 4'h5, 1);
      vecs[9] = mk(OP_SUB, 32'h8000, 32'h0001, 1'b1, 1'b0, 1'b1, 32'h0000_7FFE, 4'h8, 1);

      // Power-on reset
      Reset_n = 1'b0;
      tick();
      tick();
      Reset_n = 1'b1;
      check("reset rsp_valid", {31'b0, RspValid}, 32'd0);
      check("reset req_ready", {31'b0, ReqReady}, 32'd1);
      check("reset flags", {28'b0, Flags}, 32'd0);
      check("reset rsp_y", RspY, 32'd0);

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i], $sformatf("vec%0d", i));
         release_rsp($sformatf("vec%0d", i));
         check($sformatf("vec%0d req_ready_back", i), {31'b0, ReqReady}, 32'd1);
      end

      // Reset asserted for two edges while the op is in EXEC_LO
      ReqValid = 1'b1; ReqOp = OP_ADD; ReqA = 32'h0011; ReqB = 32'h0022;
      ReqUseCarry = 1'b0; ReqWide = 1'b0;
      tick();
      ReqValid = 1'b0;
      Reset_n = 1'b0;
      tick();
      tick();
      Reset_n = 1'b1;
      check("midreset req_ready", {31'b0, ReqReady}, 32'd1);
      check("midreset rsp_valid", {31'b0, RspValid}, 32'd0);
      check("midreset flags", {28'b0, Flags}, 32'd0);
      check("midreset alu_a", {16'b0, AluA}, 32'd0);
      check("midreset rsp_y", RspY, 32'd0);
      tick();
      check("midreset dropped", {31'b0, RspValid}, 32'd0);

      // Backpressure: response held for 5 cycles, a request pulse must be ignored
      bp = mk(OP_ADD, 32'h1234, 32'h0101, 1'b0, 1'b0, 1'b0, 32'h0000_1335, 4'h0, 1);
      issue(bp, "bp");
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            ReqValid = 1'b1; ReqA = 32'hAAAA; ReqB = 32'h5555; ReqOp = OP_SUB;
         end else begin
            ReqValid = 1'b0;
         end
         tick();
         bad = (RspY !== 32'h0000_1335) || (RspFlags !== 4'h0) || (ReqReady !== 1'b0)
               || (RspValid !== 1'b1);
         check($sformatf("bp hold c%0d", c), {31'b0, bad}, 32'd0);
      end
      ReqValid = 1'b0;
      release_rsp("bp");
      tick();
      check("bp pulse ignored rsp_valid", {31'b0, RspValid}, 32'd0);
      check("bp pulse ignored alu_a", {16'b0, AluA}, 32'h0000_1234);

      // Back-to-back narrow ops with RspReady held high: one accept every 3 cycles
      RspReady = 1'b1;
      ReqValid = 1'b1; ReqOp = OP_ADD; ReqA = 32'h0001; ReqB = 32'h0002;
      ReqUseCarry = 1'b0; ReqWide = 1'b0;
      accepts = 0;
      for (int c = 0; c < 9; c++) begin
         if (ReqValid && ReqReady) accepts++;
         if (c == 8) ReqValid = 1'b0;
         else tick();
      end
      tick();
      RspReady = 1'b0;
      check("issue interval accepts", accepts, 32'd3);
      check("issue interval rsp_y", RspY, 32'h0000_0003);
      check("issue interval idle", {31'b0, ReqReady}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
